// File: rtl/axil_lsu.sv
// axil_lsu: load/store/fetch unit bridging a single pipeline request port
// to an AXI4-Lite master. Handles 8/16/32/64-bit accesses, bus error
// decoding and a per-state watchdog.
module axil_lsu #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic                req_fetch,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [1:0]          resp_err,
  output logic                busy,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, DONE} state_t;

  state_t              state_q, state_n;
  logic [1:0]          size_q, size_n;
  logic                signed_q, signed_n;
  logic [31:0]         cnt_q, cnt_n;

  logic                req_ready_n, resp_valid_n, busy_n;
  logic [DATA_W-1:0]   resp_data_n;
  logic [1:0]          resp_err_n;
  logic                awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic [ADDR_W-1:0]   awaddr_n, araddr_n;
  logic [2:0]          awprot_n, arprot_n;
  logic [DATA_W-1:0]   wdata_n;
  logic [NB-1:0]       wstrb_n;

  logic [1:0]          acc_size;
  logic                acc_we;
  logic                aligned;
  logic [OFF_W-1:0]    acc_off;
  logic [7:0]          strb_base;
  logic [15:0]         strb_full;
  logic                expired;
  logic                complete;
  logic [1:0]          err_c;
  logic [DATA_W-1:0]   data_c;

  // Shift the addressed lane down, keep the access width, then extend.
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] rd,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [1:0]        sz,
                                                input logic              sgn);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic              sbit;
    sh = rd >> {off, 3'b000};
    unique case (sz)
      2'b00:   begin mask = DATA_W'(8'hFF);          sbit = sh[7];  end
      2'b01:   begin mask = DATA_W'(16'hFFFF);       sbit = sh[15]; end
      2'b10:   begin mask = DATA_W'(32'hFFFF_FFFF);  sbit = sh[31]; end
      default: begin mask = '1;                      sbit = 1'b0;   end
    endcase
    return (sh & mask) | ((sgn && sbit) ? ~mask : '0);
  endfunction

  // Copy the low access-sized chunk of store data into every byte lane.
  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] wd,
                                                  input logic [1:0]        sz);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      unique case (sz)
        2'b00:   r[8*i +: 8] = wd[7:0];
        2'b01:   r[8*i +: 8] = wd[8*(i%2) +: 8];
        2'b10:   r[8*i +: 8] = wd[8*(i%4) +: 8];
        default: r[8*i +: 8] = wd[8*i +: 8];
      endcase
    end
    return r;
  endfunction

  // Request decode: fetch forces a word read; check natural alignment.
  always_comb begin
    acc_size = req_fetch ? 2'b10 : req_size;
    acc_we   = req_we && !req_fetch;
    acc_off  = req_addr[OFF_W-1:0];
    unique case (acc_size)
      2'b00:   begin aligned = 1'b1;                      strb_base = 8'h01; end
      2'b01:   begin aligned = (req_addr[0] == 1'b0);     strb_base = 8'h03; end
      2'b10:   begin aligned = (req_addr[1:0] == 2'b00);  strb_base = 8'h0F; end
      default: begin aligned = (DATA_W == 64) && (req_addr[2:0] == 3'b000);
                     strb_base = 8'hFF; end
    endcase
    strb_full = {8'h00, strb_base} << acc_off;
    expired   = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));
  end

  // Next-state and next-output logic; every completion path funnels through
  // one block so DONE entry always drops all valids/readies together.
  always_comb begin
    state_n      = state_q;
    size_n       = size_q;
    signed_n     = signed_q;
    resp_valid_n = 1'b0;
    resp_data_n  = resp_data;
    resp_err_n   = resp_err;
    awvalid_n    = awvalid;
    awaddr_n     = awaddr;
    awprot_n     = awprot;
    wvalid_n     = wvalid;
    wdata_n      = wdata;
    wstrb_n      = wstrb;
    bready_n     = bready;
    arvalid_n    = arvalid;
    araddr_n     = araddr;
    arprot_n     = arprot;
    rready_n     = rready;
    complete     = 1'b0;
    err_c        = 2'b00;
    data_c       = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_n   = acc_size;
          signed_n = req_signed;
          if (!aligned) begin
            complete = 1'b1;
            err_c    = 2'b01;
          end else if (acc_we) begin
            state_n   = WR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            awaddr_n  = req_addr;
            awprot_n  = 3'b000;
            wdata_n   = replicate(req_wdata, acc_size);
            wstrb_n   = strb_full[NB-1:0];
          end else begin
            state_n   = RD_A;
            arvalid_n = 1'b1;
            rready_n  = 1'b1;
            araddr_n  = req_addr;
            arprot_n  = req_fetch ? 3'b100 : 3'b000;
          end
        end
      end
      RD_A, RD_D: begin
        if (arvalid && arready) arvalid_n = 1'b0;
        if (rvalid) begin
          complete = 1'b1;
          err_c    = (rresp != 2'b00) ? 2'b10 : 2'b00;
          data_c   = (rresp != 2'b00) ? '0 : extract(rdata, araddr[OFF_W-1:0], size_q, signed_q);
        end else if (arvalid && arready) begin
          state_n = RD_D;
        end else if (expired) begin
          complete = 1'b1;
          err_c    = 2'b11;
        end
      end
      WR: begin
        if (awready) awvalid_n = 1'b0;
        if (wready)  wvalid_n  = 1'b0;
        if ((!awvalid || awready) && (!wvalid || wready)) begin
          state_n  = WR_B;
          bready_n = 1'b1;
        end else if (expired) begin
          complete = 1'b1;
          err_c    = 2'b11;
        end
      end
      WR_B: begin
        if (bvalid) begin
          complete = 1'b1;
          err_c    = (bresp != 2'b00) ? 2'b10 : 2'b00;
        end else if (expired) begin
          complete = 1'b1;
          err_c    = 2'b11;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (complete) begin
      state_n      = DONE;
      resp_valid_n = 1'b1;
      resp_err_n   = err_c;
      resp_data_n  = data_c;
      arvalid_n    = 1'b0;
      rready_n     = 1'b0;
      awvalid_n    = 1'b0;
      wvalid_n     = 1'b0;
      bready_n     = 1'b0;
    end
    cnt_n       = (state_q == IDLE || state_n != state_q) ? '0 : cnt_q + 32'd1;
    req_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
  end

  // State, latched request fields and all registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      size_q     <= '0;
      signed_q   <= 1'b0;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= '0;
      busy       <= 1'b0;
      awvalid    <= 1'b0;
      awaddr     <= '0;
      awprot     <= '0;
      wvalid     <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arprot     <= '0;
      rready     <= 1'b0;
    end else begin
      state_q    <= state_n;
      size_q     <= size_n;
      signed_q   <= signed_n;
      cnt_q      <= cnt_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_data  <= resp_data_n;
      resp_err   <= resp_err_n;
      busy       <= busy_n;
      awvalid    <= awvalid_n;
      awaddr     <= awaddr_n;
      awprot     <= awprot_n;
      wvalid     <= wvalid_n;
      wdata      <= wdata_n;
      wstrb      <= wstrb_n;
      bready     <= bready_n;
      arvalid    <= arvalid_n;
      araddr     <= araddr_n;
      arprot     <= arprot_n;
      rready     <= rready_n;
    end
  end

endmodule
